// File: rtl/ring_link_pipe.sv
// ---------------------------------------------------------------------------
// ring_link_pipe
//   Credit-flow-controlled pipelined link for ring-bus hops. N_CH independent
//   lanes each cross PIPENUM forward register stages into a per-lane sink
//   FIFO. Every pop sends a one-bit token back over a matching PIPENUM-stage
//   credit-return pipe. The source may send only while it holds credit, so
//   a sink FIFO can never overflow, however much backpressure there is.
//
// Ports
//   clk, rst     clock; synchronous active-high reset (dominates ce)
//   ce           clock enable; 0 freezes every register and blocks handshakes
//   flush        synchronous clear of all lane state, same effect as rst
//   in_valid     [N_CH]        per-lane source valid
//   in_ready     [N_CH]        per-lane accept (credit available, live)
//   in_data      [N_CH*D_W]    lane c at [c*D_W +: D_W]
//   out_valid    [N_CH]        per-lane sink FIFO non-empty (live)
//   out_ready    [N_CH]        per-lane consumer pop
//   out_data     [N_CH*D_W]    FIFO head, first-word-fall-through, 0 when empty
//   credit_cnt   [N_CH*CNT_W]  per-lane credit counter
// ---------------------------------------------------------------------------
module ring_link_pipe #(
    parameter int D_W        = 64,
    parameter int N_CH       = 4,
    parameter int PIPENUM    = 12,
    parameter int FIFO_DEPTH = 32,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  flush,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [N_CH*D_W-1:0]   in_data,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic [N_CH*D_W-1:0]   out_data,
    output logic [N_CH*CNT_W-1:0] credit_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Handshakes may only complete when the block is running this cycle.
    // Gating both ready and valid with this keeps a frozen or clearing
    // block from ever reporting a transfer that its registers would not record.
    logic live;
    assign live = ce && !flush && !rst;

    genvar c;
    generate
        for (c = 0; c < N_CH; c++) begin : g_lane
            logic [D_W-1:0]     lane_in;
            logic [PIPENUM-1:0] fwd_vld;
            logic [D_W-1:0]     fwd_data [PIPENUM];
            logic [PIPENUM-1:0] tok;
            logic [CNT_W-1:0]   credit;
            logic [D_W-1:0]     mem [FIFO_DEPTH];
            // Extra MSB is the wrap bit: equal pointers = empty, MSB differing
            // with equal low bits = full.
            logic [AW:0]        wr_ptr;
            logic [AW:0]        rd_ptr;
            logic               empty;
            logic               accept;
            logic               pop;
            logic               arrive;
            logic               ret;

            assign lane_in = in_data[c*D_W +: D_W];
            assign empty   = (wr_ptr == rd_ptr);
            assign arrive  = fwd_vld[PIPENUM-1];
            assign ret     = tok[PIPENUM-1];

            assign in_ready[c]  = live && (credit != '0);
            assign out_valid[c] = live && !empty;
            assign accept       = in_valid[c] && in_ready[c];
            assign pop          = out_valid[c] && out_ready[c];

            // Head is shown even while frozen; only the valid is gated.
            assign out_data[c*D_W +: D_W]     = empty ? '0 : mem[rd_ptr[AW-1:0]];
            assign credit_cnt[c*CNT_W +: CNT_W] = credit;

            // Forward pipe, credit-return pipe, pointers and credit counter.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    fwd_vld <= '0;
                    tok     <= '0;
                    for (int k = 0; k < PIPENUM; k++) begin
                        fwd_data[k] <= '0;
                    end
                    wr_ptr  <= '0;
                    rd_ptr  <= '0;
                    credit  <= CNT_W'(FIFO_DEPTH);
                end else if (ce) begin
                    // Stage boundary: source -> stage 0. An idle cycle leaves a
                    // bubble (valid 0) and holds the old data to save toggles.
                    fwd_vld[0] <= accept;
                    tok[0]     <= pop;
                    if (accept) begin
                        fwd_data[0] <= lane_in;
                    end
                    // Stage boundaries: stage k-1 -> stage k.
                    for (int k = PIPENUM - 1; k >= 1; k--) begin
                        fwd_vld[k]  <= fwd_vld[k-1];
                        fwd_data[k] <= fwd_data[k-1];
                        tok[k]      <= tok[k-1];
                    end
                    // Stage boundary: last stage -> sink FIFO.
                    if (arrive) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    // A send and a returning token in the same cycle cancel.
                    case ({accept, ret})
                        2'b10:   credit <= credit - CNT_W'(1);
                        2'b01:   credit <= credit + CNT_W'(1);
                        default: credit <= credit;
                    endcase
                end
            end

            // FIFO storage carries no reset; pointers alone define its contents.
            always_ff @(posedge clk) begin
                if (!rst && !flush && ce && arrive) begin
                    mem[wr_ptr[AW-1:0]] <= fwd_data[PIPENUM-1];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ring_link_pipe.sv
module tb_ring_link_pipe;

    localparam int D_W        = 64;
    localparam int N_CH       = 4;
    localparam int PIPENUM    = 12;
    localparam int FIFO_DEPTH = 32;
    localparam int CNT_W      = 6;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  ce = 1'b1;
    logic                  flush = 1'b0;
    logic [N_CH-1:0]       in_valid = '0;
    logic [N_CH-1:0]       in_ready;
    logic [N_CH*D_W-1:0]   in_data = '0;
    logic [N_CH-1:0]       out_valid;
    logic [N_CH-1:0]       out_ready = '0;
    logic [N_CH*D_W-1:0]   out_data;
    logic [N_CH*CNT_W-1:0] credit_cnt;

    ring_link_pipe #(
        .D_W(D_W), .N_CH(N_CH), .PIPENUM(PIPENUM), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .credit_cnt(credit_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of the link (per lane)
    logic        m_fv [N_CH][PIPENUM];
    logic [63:0] m_fd [N_CH][PIPENUM];
    logic        m_tk [N_CH][PIPENUM];
    int          m_credit [N_CH];
    logic [63:0] m_mem [N_CH][64];
    int          m_head [N_CH];
    int          m_cnt [N_CH];

    // Bench bookkeeping
    int          cyc = 0;
    int          s_cyc;
    bit          chk_en = 1'b0;
    bit          auto_data = 1'b1;
    int          tx_cnt [N_CH];
    int          acc_cnt [N_CH];
    int          rx_cnt [N_CH];
    logic [N_CH-1:0]     s_in_ready;
    logic [N_CH-1:0]     s_out_valid;
    logic [63:0]         s_out_data [N_CH];
    int                  s_credit [N_CH];

    task automatic model_reset(input int c);
        for (int k = 0; k < PIPENUM; k++) begin
            m_fv[c][k] = 1'b0;
            m_fd[c][k] = '0;
            m_tk[c][k] = 1'b0;
        end
        m_credit[c] = FIFO_DEPTH;
        m_head[c]   = 0;
        m_cnt[c]    = 0;
    endtask

    task automatic clr();
        for (int c = 0; c < N_CH; c++) begin
            acc_cnt[c] = 0;
            rx_cnt[c]  = 0;
        end
    endtask

    // One clock cycle: drive data, sample and compare at negedge, advance model.
    task automatic step();
        logic e_rdy, e_ov, acc, pop, wr, tk;
        logic [63:0] e_od, wdata, din;
        int inflight, toks;
        if (auto_data) begin
            for (int c = 0; c < N_CH; c++) begin
                in_data[c*D_W +: D_W] = {8'(c), 24'hC0FFEE, 32'(tx_cnt[c])};
            end
        end
        @(negedge clk);
        s_cyc = cyc;
        for (int c = 0; c < N_CH; c++) begin
            e_rdy = (m_credit[c] != 0) && ce && !flush && !rst;
            e_ov  = (m_cnt[c] != 0) && ce && !flush && !rst;
            e_od  = (m_cnt[c] != 0) ? m_mem[c][m_head[c]] : 64'd0;
            s_in_ready[c]  = in_ready[c];
            s_out_valid[c] = out_valid[c];
            s_out_data[c]  = out_data[c*D_W +: D_W];
            s_credit[c]    = int'(credit_cnt[c*CNT_W +: CNT_W]);
            if (chk_en) begin
                inflight = 0;
                toks = 0;
                for (int k = 0; k < PIPENUM; k++) begin
                    inflight += int'(m_fv[c][k]);
                    toks     += int'(m_tk[c][k]);
                end
                chk($sformatf("in_ready[%0d]@%0d", c, cyc), 64'(in_ready[c]), 64'(e_rdy));
                chk($sformatf("out_valid[%0d]@%0d", c, cyc), 64'(out_valid[c]), 64'(e_ov));
                chk($sformatf("out_data[%0d]@%0d", c, cyc), s_out_data[c], e_od);
                chk($sformatf("credit[%0d]@%0d", c, cyc), 64'(s_credit[c]), 64'(m_credit[c]));
                chk($sformatf("invariant[%0d]@%0d", c, cyc),
                    64'(s_credit[c] + inflight + m_cnt[c] + toks), 64'(FIFO_DEPTH));
            end
            if (rst || flush) begin
                model_reset(c);
            end else if (ce) begin
                din   = in_data[c*D_W +: D_W];
                acc   = in_valid[c] && e_rdy;
                pop   = e_ov && out_ready[c];
                wr    = m_fv[c][PIPENUM-1];
                wdata = m_fd[c][PIPENUM-1];
                tk    = m_tk[c][PIPENUM-1];
                for (int k = PIPENUM - 1; k >= 1; k--) begin
                    m_fv[c][k] = m_fv[c][k-1];
                    m_fd[c][k] = m_fd[c][k-1];
                    m_tk[c][k] = m_tk[c][k-1];
                end
                m_fv[c][0] = acc;
                m_tk[c][0] = pop;
                if (acc) m_fd[c][0] = din;
                if (pop) begin
                    m_head[c] = (m_head[c] + 1) % 64;
                    m_cnt[c]--;
                    rx_cnt[c]++;
                end
                if (wr) begin
                    m_mem[c][(m_head[c] + m_cnt[c]) % 64] = wdata;
                    m_cnt[c]++;
                end
                if (acc) begin
                    m_credit[c]--;
                    acc_cnt[c]++;
                    tx_cnt[c]++;
                end
                if (tk) m_credit[c]++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = '0;
        out_ready = '0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    int first_cyc;
    logic [63:0] first_data;
    int k_wait;
    int drops;
    int stale;
    int loops;

    initial begin
        for (int c = 0; c < N_CH; c++) begin
            tx_cnt[c] = 0;
            model_reset(c);
        end
        clr();
        #1;

        // Reset, then reset-state checks
        step();
        chk_en = 1'b1;
        do_reset(2);
        step();
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("rst_credit[%0d]", c), 64'(s_credit[c]), 64'd32);
        end
        chk("rst_out_valid", 64'(s_out_valid), 64'h0);
        chk("rst_in_ready", 64'(s_in_ready), 64'hF);

        // T1: latency on lane 0
        auto_data = 1'b0;
        in_data = '0;
        out_ready = '1;
        while (cyc < 10) step();
        in_valid = 4'b0001;
        in_data[D_W-1:0] = 64'hA5;
        step();
        chk("t1_send_ready", 64'(s_in_ready[0]), 64'd1);
        in_valid = '0;
        first_cyc = -1;
        first_data = '0;
        while (cyc < 40) begin
            step();
            if (first_cyc < 0 && s_out_valid[0]) begin
                first_cyc = s_cyc;
                first_data = s_out_data[0];
            end
        end
        chk("t1_first_cycle", 64'(first_cyc), 64'd23);
        chk("t1_data", first_data, 64'hA5);
        auto_data = 1'b1;

        // T2: credit exhaustion on lane 0
        do_reset(2);
        clr();
        out_ready = '0;
        in_valid = 4'b0001;
        repeat (50) step();
        chk("t2_accepts", 64'(acc_cnt[0]), 64'd32);
        chk("t2_credit", 64'(s_credit[0]), 64'd0);
        chk("t2_in_ready", 64'(s_in_ready[0]), 64'd0);
        out_ready = 4'b0001;
        step();
        chk("t2_pop_valid", 64'(s_out_valid[0]), 64'd1);
        out_ready = '0;
        k_wait = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k_wait < 0 && s_in_ready[0]) k_wait = k;
        end
        chk("t2_credit_return", 64'(k_wait), 64'd13);
        in_valid = '0;
        out_ready = '1;
        repeat (80) step();
        chk("t2_no_loss", 64'(rx_cnt[0]), 64'(acc_cnt[0]));

        // T3: full throughput, 1000 words per lane
        do_reset(2);
        clr();
        out_ready = '1;
        drops = 0;
        loops = 0;
        while ((acc_cnt[0] < 1000 || acc_cnt[1] < 1000 || acc_cnt[2] < 1000 ||
                acc_cnt[3] < 1000) && loops < 1200) begin
            for (int c = 0; c < N_CH; c++) in_valid[c] = (acc_cnt[c] < 1000);
            step();
            loops++;
            for (int c = 0; c < N_CH; c++) begin
                if (in_valid[c] && !s_in_ready[c]) drops++;
            end
        end
        in_valid = '0;
        repeat (40) step();
        chk("t3_cycles", 64'(loops), 64'd1000);
        chk("t3_ready_drops", 64'(drops), 64'd0);
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("t3_rx[%0d]", c), 64'(rx_cnt[c]), 64'd1000);
        end

        // T4: lane 1 stalled, others streaming
        do_reset(2);
        clr();
        out_ready = 4'b1101;
        in_valid = '1;
        repeat (200) step();
        chk("t4_lane1_acc", 64'(acc_cnt[1]), 64'd32);
        chk("t4_lane1_credit", 64'(s_credit[1]), 64'd0);
        for (int c = 0; c < N_CH; c++) begin
            if (c != 1) begin
                chk($sformatf("t4_acc[%0d]", c), 64'(acc_cnt[c]), 64'd200);
                chk($sformatf("t4_rx[%0d]", c), 64'(rx_cnt[c]), 64'd187);
            end
        end
        in_valid = '0;
        out_ready = '1;
        repeat (60) step();
        chk("t4_lane1_drain", 64'(rx_cnt[1]), 64'd32);

        // T5: clock-enable freeze mid-stream, then flush
        do_reset(2);
        clr();
        in_valid = '1;
        out_ready = '1;
        repeat (30) step();
        ce = 1'b0;
        repeat (5) begin
            step();
            chk("t5_frozen_ready", 64'(s_in_ready), 64'h0);
            chk("t5_frozen_valid", 64'(s_out_valid), 64'h0);
        end
        ce = 1'b1;
        repeat (30) step();
        in_valid = '0;
        repeat (40) step();
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("t5_ce_no_loss[%0d]", c), 64'(rx_cnt[c]), 64'(acc_cnt[c]));
            chk($sformatf("t5_ce_count[%0d]", c), 64'(acc_cnt[c]), 64'd60);
        end
        in_valid = '1;
        out_ready = 4'b0101;
        repeat (20) step();
        flush = 1'b1;
        step();
        chk("t5_flush_ready", 64'(s_in_ready), 64'h0);
        flush = 1'b0;
        in_valid = '0;
        out_ready = '1;
        step();
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("t5_flush_credit[%0d]", c), 64'(s_credit[c]), 64'd32);
        end
        chk("t5_flush_out_valid", 64'(s_out_valid), 64'h0);
        stale = 0;
        repeat (30) begin
            step();
            if (s_out_valid != '0) stale++;
        end
        chk("t5_stale", 64'(stale), 64'd0);

        // T6: random valid/ready/ce
        do_reset(2);
        clr();
        repeat (2000) begin
            ce = ($urandom_range(9, 0) != 0);
            in_valid = 4'($urandom_range(15, 0));
            out_ready = 4'($urandom_range(15, 0));
            step();
        end
        ce = 1'b1;
        in_valid = '0;
        out_ready = '1;
        repeat (60) step();
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("t6_no_loss[%0d]", c), 64'(rx_cnt[c]), 64'(acc_cnt[c]));
            chk($sformatf("t6_credit_home[%0d]", c), 64'(s_credit[c]), 64'd32);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
